reset_sequencer: RTL
====================

# reset_sequencer

Staged power-up / power-down enable sequencer for the 40 MHz domain. Releases STAGES subsystem enables one at a time, in ascending order. Each release follows a fixed settle delay and waits for that stage's ready acknowledge. Supervises the ready lines while running, tears enables down in reverse order on loss of ready or on request, retries a bounded number of times, then latches a fault.

## Interface
Parameters:
- STAGES, 4: number of enable stages (2..8).
- DELAY, 62: settle cycles before each stage enable is asserted (≥1).
- TIMEOUT, 1023: max cycles to wait for a stage's ready after its enable (≥2).
- RETRIES, 3: automatic restarts allowed before latching fault (0..7).

Ports:
- clk40  in  1  40 MHz clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- soft_req  in  1  single-cycle restart request.
- rdy  in  STAGES  per-stage ready acknowledge; level, synchronous to clk40.
- en  out  STAGES  per-stage enable; en[0] first up, last down.
- all_up  out  1  all stages enabled and ready.
- fault  out  1  retries exhausted; sequencer halted.
- fault_stage  out  $clog2(STAGES)  index of the stage that caused the last fail event.
- retry_cnt  out  3  automatic retries consumed.

## Operation
- States: IDLE, DELAY, WAIT, UP, DOWN, FAULT. Registers: stage index k, cycle counter cnt (wide enough for max(DELAY, TIMEOUT)).
- rst high: state IDLE, k=0, cnt=0. All outputs 0.
- IDLE: on the first edge with rst low, go to DELAY with cnt=0.
- DELAY: cnt increments each edge. At cnt==DELAY-1, set en[k]=1, clear cnt, go to WAIT.
- WAIT:
  - rdy[k]=1 sampled: if k<STAGES-1, k++ and go to DELAY; else set all_up=1 and go to UP.
  - cnt==TIMEOUT-1 with rdy[k]=0: fail event, fault_stage=k.
- Fail event in DELAY or WAIT: any rdy[j]=0 for j<k. fault_stage = lowest such j.
- UP: any rdy bit 0 causes a fail event, fault_stage = lowest dropped index. all_up stays 1 otherwise.
- Fail event handling:
  - retry_cnt<RETRIES: retry_cnt++, all_up=0, go to DOWN.
  - Otherwise: fault=1, go to DOWN, then FAULT.
- soft_req:
  - In UP: retry_cnt=0, all_up=0, go to DOWN. Not a fail event.
  - In FAULT: fault=0, retry_cnt=0, go to DELAY with k=0.
  - Ignored in IDLE, DELAY, WAIT, DOWN.
- DOWN: each edge clears the highest set en bit. On the edge that clears the last set bit, k=0, cnt=0, and next state is DELAY, or FAULT if fault=1.
  - DOWN entered with en already all 0: leaves on the next edge.
- FAULT: en all 0. fault, fault_stage and retry_cnt hold until soft_req or rst.
- Width rules: retry_cnt saturates at RETRIES; the counter never wraps. k never exceeds STAGES-1.

## Timing
- Reset value of every output: 0. rst takes priority over every other input on the same edge.
- rst asserted mid-sequence: all en drop on the same edge. No reverse teardown.
- rst sampled low at edge E0: en[0] rises at edge E0+DELAY.
- rdy[k] sampled high at edge Ek: en[k+1] rises at Ek+DELAY.
- Last stage: rdy[STAGES-1] high at edge E gives all_up=1 at E.
- rdy[k] and timeout on the same edge: rdy wins.
- Fail event and soft_req on the same UP edge: soft_req wins; retry_cnt is cleared, not incremented.
- Teardown latency: n enabled stages clear in n cycles, one per edge, highest first. Restart's DELAY count begins on the edge after the last clear.
- UP detection: rdy drop to all_up=0 takes one edge. en[STAGES-1] clears on that same edge's DOWN entry plus one.
- Only one en bit changes per edge, in every state.

## Test plan
Parameters for all scenarios: STAGES=4, DELAY=4, TIMEOUT=16, RETRIES=2.
- Clean power-up: rst released at E0; bench raises rdy[k] 2 cycles after en[k] -> en rises at E0+4, +10, +16, +22; all_up=1 at E0+24; fault=0, retry_cnt=0.
- Timeout path: rdy[2] held 0 -> after 16 WAIT cycles en clears in order 2,1,0 (one per cycle); retry_cnt=1; sequence restarts with en[0] 4 cycles later. Third timeout -> fault=1, fault_stage=2, retry_cnt=2, en=0000.
- Drop in UP: all_up=1, then drop rdy[1] and rdy[3] on the same cycle -> all_up=0 next edge; fault_stage=1; retry_cnt=1; teardown 3,2,1,0.
- soft_req: soft_req in UP -> teardown with retry_cnt=0, then full re-sequence. soft_req in FAULT -> fault=0, en[0] rises DELAY edges later. soft_req in WAIT -> no effect.
- Reset mid-op: rst asserted during WAIT at stage 2 -> en=0000, all outputs 0 on that edge. rst released -> en[0] at +4.
- Tie case: rdy[1] rises on the exact timeout edge -> treated as ready; retry_cnt unchanged; proceeds to stage 2.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
//   Bundles the sequencer's request/acknowledge/status signals.
//   master : the sequencer (drives enables and status, samples requests)
//   slave  : the controlled side (drives soft_req and rdy, observes the rest)
// Signals:
//   soft_req     single-cycle restart request
//   rdy          per-stage ready acknowledge (level, clk40 domain)
//   en           per-stage enable, en[0] first up, last down
//   all_up       every stage enabled and acknowledged
//   fault        retries exhausted, sequencer halted
//   fault_stage  stage index blamed for the most recent fail event
//   retry_cnt    automatic restarts consumed
interface reset_sequencer_if #(
  parameter int STAGES = 4
) ();
  localparam int K_W = $clog2(STAGES);

  logic              soft_req;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] en;
  logic              all_up;
  logic              fault;
  logic [K_W-1:0]    fault_stage;
  logic [2:0]        retry_cnt;

  modport master (
    input  soft_req, rdy,
    output en, all_up, fault, fault_stage, retry_cnt
  );

  modport slave (
    output soft_req, rdy,
    input  en, all_up, fault, fault_stage, retry_cnt
  );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Staged power-up / power-down enable sequencer (40 MHz domain).
//   Stages are enabled one at a time in ascending order, each after a settle
//   delay and gated on the previous stage's ready. Ready lines are
//   supervised; on loss of ready (or a timeout) the enables are torn down
//   highest-first, the sequence restarts a bounded number of times and then
//   a fault is latched until soft_req or rst.
// Ports:
//   clk40  40 MHz clock, rising edge
//   rst    synchronous active-high reset, clears every register and output
//   bus    reset_sequencer_if.master (soft_req, rdy in; en, all_up, fault,
//          fault_stage, retry_cnt out)
module reset_sequencer #(
  parameter int STAGES  = 4,
  parameter int DELAY   = 62,
  parameter int TIMEOUT = 1023,
  parameter int RETRIES = 3
) (
  input logic              clk40,
  input logic              rst,
  reset_sequencer_if.master bus
);

  localparam int K_W     = $clog2(STAGES);
  localparam int CNT_MAX = (DELAY > TIMEOUT) ? DELAY : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(STAGES - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_WAIT,
    S_UP,
    S_DOWN,
    S_FAULT
  } state_t;

  state_t state, state_nxt;

  logic [K_W-1:0]    k, k_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [STAGES-1:0] en, en_nxt;
  logic              all_up, all_up_nxt;
  logic              fault, fault_nxt;
  logic [K_W-1:0]    fault_stage, fault_stage_nxt;
  logic [2:0]        retry_cnt, retry_cnt_nxt;

  logic [STAGES-1:0] rdy;
  logic              soft_req;
  logic              drop_found;
  logic [K_W-1:0]    drop_idx;
  logic              fail_ev;
  logic              last_clear;

  assign rdy      = bus.rdy;
  assign soft_req = bus.soft_req;

  // Clear the highest set bit; teardown removes stages from the top down.
  function automatic logic [STAGES-1:0] clear_top(input logic [STAGES-1:0] v);
    logic [STAGES-1:0] r;
    logic              done;
    r    = v;
    done = 1'b0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      if (!done && v[j]) begin
        r[j] = 1'b0;
        done = 1'b1;
      end
    end
    return r;
  endfunction

  // Saturating retry increment; the counter never wraps past RETRIES.
  function automatic logic [2:0] retry_step(input logic [2:0] r);
    return (r < RETRY_MAX) ? r + 3'd1 : r;
  endfunction

  // Lowest supervised stage whose ready is low. While sequencing only the
  // stages below k are supervised; in UP every stage is.
  always_comb begin
    drop_found = 1'b0;
    drop_idx   = '0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      if (!rdy[j] && (state == S_UP || j < int'(k))) begin
        drop_found = 1'b1;
        drop_idx   = K_W'(j);
      end
    end
  end

  // At most one enable left, so this DOWN edge empties the vector (or it
  // was already empty and DOWN exits immediately).
  assign last_clear = ((en & (en - STAGES'(1))) == '0);

  // State register
  always_ff @(posedge clk40) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    fail_ev   = 1'b0;
    unique case (state)
      S_IDLE: state_nxt = S_DELAY;
      S_DELAY: begin
        if (drop_found) begin
          fail_ev = 1'b1;
        end else if (cnt == DLY_LAST) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // ready beats a timeout landing on the same edge
        if (drop_found) begin
          fail_ev = 1'b1;
        end else if (rdy[k]) begin
          state_nxt = (k == K_LAST) ? S_UP : S_DELAY;
        end else if (cnt == TO_LAST) begin
          fail_ev = 1'b1;
        end
      end
      S_UP: begin
        // an operator restart overrides a simultaneous ready loss
        if (soft_req) begin
          state_nxt = S_DOWN;
        end else if (drop_found) begin
          fail_ev = 1'b1;
        end
      end
      S_DOWN: begin
        if (last_clear) begin
          state_nxt = fault ? S_FAULT : S_DELAY;
        end
      end
      S_FAULT: begin
        if (soft_req) begin
          state_nxt = S_DELAY;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (fail_ev) begin
      state_nxt = S_DOWN;
    end
  end

  // Output / datapath next values
  always_comb begin
    k_nxt           = k;
    cnt_nxt         = cnt;
    en_nxt          = en;
    all_up_nxt      = all_up;
    fault_nxt       = fault;
    fault_stage_nxt = fault_stage;
    retry_cnt_nxt   = retry_cnt;

    unique case (state)
      S_IDLE: begin
        k_nxt   = '0;
        cnt_nxt = '0;
      end
      S_DELAY: begin
        if (!fail_ev) begin
          if (cnt == DLY_LAST) begin
            en_nxt[k] = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (!fail_ev) begin
          if (rdy[k]) begin
            cnt_nxt = '0;
            if (k == K_LAST) begin
              all_up_nxt = 1'b1;
            end else begin
              k_nxt = k + K_W'(1);
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_UP: begin
        if (soft_req) begin
          retry_cnt_nxt = '0;
          all_up_nxt    = 1'b0;
        end
      end
      S_DOWN: begin
        en_nxt = clear_top(en);
        if (last_clear) begin
          k_nxt   = '0;
          cnt_nxt = '0;
        end
      end
      S_FAULT: begin
        if (soft_req) begin
          fault_nxt     = 1'b0;
          retry_cnt_nxt = '0;
          k_nxt         = '0;
          cnt_nxt       = '0;
        end
      end
      default: begin
        k_nxt   = '0;
        cnt_nxt = '0;
      end
    endcase

    // A timeout blames the waiting stage; a ready loss blames the lowest drop.
    if (fail_ev) begin
      fault_stage_nxt = drop_found ? drop_idx : k;
      all_up_nxt      = 1'b0;
      retry_cnt_nxt   = retry_step(retry_cnt);
      if (retry_cnt >= RETRY_MAX) begin
        fault_nxt = 1'b1;
      end
    end
  end

  // Datapath / output registers; rst drops every enable at once.
  always_ff @(posedge clk40) begin
    if (rst) begin
      k           <= '0;
      cnt         <= '0;
      en          <= '0;
      all_up      <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= '0;
      retry_cnt   <= '0;
    end else begin
      k           <= k_nxt;
      cnt         <= cnt_nxt;
      en          <= en_nxt;
      all_up      <= all_up_nxt;
      fault       <= fault_nxt;
      fault_stage <= fault_stage_nxt;
      retry_cnt   <= retry_cnt_nxt;
    end
  end

  assign bus.en          = en;
  assign bus.all_up      = all_up;
  assign bus.fault       = fault;
  assign bus.fault_stage = fault_stage;
  assign bus.retry_cnt   = retry_cnt;

endmodule
